// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read port.
// Imported by spi_flash_reader.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV
  } state_t;

  localparam logic [7:0] SPI_READ_CMD  = 8'h03;
  localparam int         SPI_XFER_BITS = 32;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// SPI READ (0x03) slave for the core's flash window.
// One word per strobe, fixed 128-cycle latency.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_WIDTH = 24,
  parameter logic [7:0] READ_CMD   = SPI_READ_CMD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rstrb,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           rdata,
  output logic                  rbusy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [4:0] LAST = 5'(SPI_XFER_BITS - 1);

  state_t      state, state_next;
  logic        phase;
  logic [4:0]  cnt;
  logic [31:0] shift;
  logic [31:0] rx;
  logic [31:0] rx_next;
  logic [31:0] load;
  logic        last_bit;

  // Word-align by masking the two low address bits in the frame.
  assign load     = {READ_CMD, addr} & 32'hFFFF_FFFC;
  assign rx_next  = {rx[30:0], spi_miso};
  assign last_bit = phase && (cnt == LAST);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (rstrb)    state_next = SEND;
      SEND:    if (last_bit) state_next = RECV;
      RECV:    if (last_bit) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= 1'b0;
      cnt      <= 5'd0;
      shift    <= 32'd0;
      rx       <= 32'd0;
      rdata    <= 32'd0;
      rbusy    <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else if (state == IDLE) begin
      if (rstrb) begin
        shift    <= load;
        spi_mosi <= load[31];
        spi_cs_n <= 1'b0;
        rbusy    <= 1'b1;
        cnt      <= 5'd0;
        phase    <= 1'b0;
        spi_clk  <= 1'b0;
      end
    end else if (!phase) begin
      phase   <= 1'b1;
      spi_clk <= 1'b1;
    end else begin
      phase   <= 1'b0;
      spi_clk <= 1'b0;
      cnt     <= cnt + 5'd1;
      if (state == SEND) begin
        if (cnt == LAST) begin
          spi_mosi <= 1'b0;
        end else begin
          shift    <= {shift[30:0], 1'b0};
          spi_mosi <= shift[30];
        end
      end else begin
        rx <= rx_next;
        if (cnt == LAST) begin
          rdata    <= bswap32(rx_next);
          spi_cs_n <= 1'b1;
          rbusy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural
// SPI flash model answering READ commands.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rstrb;
  logic [23:0] addr;
  logic [31:0] rdata;
  logic        rbusy;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  spi_flash_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rstrb    (rstrb),
    .addr     (addr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  // Flash model
  logic [7:0]  mem [int];
  int          rbits = 0;
  logic [31:0] cmd_sh = 0;
  logic [31:0] last_cmd = 0;
  int          ntx = 0;

  function automatic logic [7:0] rd_byte(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      rbits  = 0;
      cmd_sh = 0;
    end else begin
      if (rbits < 32) cmd_sh = {cmd_sh[30:0], spi_mosi};
      rbits = rbits + 1;
      if (rbits == 32) last_cmd = cmd_sh;
    end
  end

  always @(negedge spi_cs_n) ntx = ntx + 1;

  always @(negedge spi_clk) begin
    if (!spi_cs_n && rbits >= 32 && rbits < 64) begin
      automatic int j = rbits - 32;
      automatic logic [7:0] b = rd_byte(int'(last_cmd[23:0]) + j / 8);
      spi_miso = b[7 - (j % 8)];
    end else begin
      spi_miso = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [23:0] a);
    addr  = a;
    rstrb = 1'b1;
    @(posedge clk);
    #1;
    rstrb = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (rbusy && n < 400) begin
      @(posedge clk);
      #1;
      if (rbusy) n++;
    end
  endtask

  int n;
  int tx0;

  initial begin
    reset_n = 1'b1;
    rstrb   = 1'b0;
    addr    = 24'h0;
    mem[32'h010000] = 8'h13;
    mem[32'h0ABCDC] = 8'hDE;
    mem[32'h0ABCDD] = 8'hAD;
    mem[32'h0ABCDE] = 8'hBE;
    mem[32'h0ABCDF] = 8'hEF;
    mem[32'h000100] = 8'h78;
    mem[32'h000101] = 8'h56;
    mem[32'h000102] = 8'h34;
    mem[32'h000103] = 8'h12;

    // Async reset, before any clock edge
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cs_n",  32'(spi_cs_n), 32'd1);
    chk("rst_sclk",  32'(spi_clk),  32'd0);
    chk("rst_mosi",  32'(spi_mosi), 32'd0);
    chk("rst_rbusy", 32'(rbusy),    32'd0);
    chk("rst_rdata", rdata,         32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Reset mid-transfer at cycle 70
    @(negedge clk);
    strobe(24'h0ABCDF);
    repeat (69) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_cs_n",  32'(spi_cs_n), 32'd1);
    chk("mid_rbusy", 32'(rbusy),    32'd0);
    chk("mid_sclk",  32'(spi_clk),  32'd0);
    chk("mid_rdata", rdata,         32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Basic read
    @(negedge clk);
    tx0 = ntx;
    strobe(24'h010000);
    chk("b_rbusy1", 32'(rbusy),    32'd1);
    chk("b_cs1",    32'(spi_cs_n), 32'd0);
    chk("b_sclk1",  32'(spi_clk),  32'd0);
    @(posedge clk);
    #1;
    chk("b_sclk2",  32'(spi_clk),  32'd1);
    wait_done(2, n);
    chk("b_busy_cycles", n, 128);
    chk("b_cmd",   last_cmd, 32'h0301_0000);
    chk("b_rdata", rdata,    32'h0000_0013);
    chk("b_cs_end", 32'(spi_cs_n), 32'd1);
    chk("b_ntx",   ntx - tx0, 1);

    // Alignment and byte order, then back-to-back
    @(negedge clk);
    strobe(24'h0ABCDF);
    wait_done(1, n);
    chk("a_busy_cycles", n, 128);
    chk("a_cmd",   last_cmd, 32'h030A_BCDC);
    chk("a_rdata", rdata,    32'hEFBE_ADDE);
    chk("bb_cs_gap", 32'(spi_cs_n), 32'd1);
    strobe(24'h000100);
    chk("bb_cs_low", 32'(spi_cs_n), 32'd0);
    chk("bb_rbusy",  32'(rbusy),    32'd1);
    wait_done(1, n);
    chk("bb_busy_cycles", n, 128);
    chk("bb_cmd",   last_cmd, 32'h0300_0100);
    chk("bb_rdata", rdata,    32'h1234_5678);

    // Strobe while busy is ignored
    @(negedge clk);
    tx0 = ntx;
    strobe(24'h010000);
    repeat (40) @(posedge clk);
    @(negedge clk);
    strobe(24'h0ABCDC);
    wait_done(42, n);
    chk("sb_busy_cycles", n, 128);
    chk("sb_cmd",   last_cmd, 32'h0301_0000);
    chk("sb_rdata", rdata,    32'h0000_0013);
    repeat (20) @(posedge clk);
    #1;
    chk("sb_idle_cs", 32'(spi_cs_n), 32'd1);
    chk("sb_idle_bz", 32'(rbusy),    32'd0);
    chk("sb_ntx",     ntx - tx0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Memory-side slave serving the core's read port for the memory-mapped SPI flash window, which holds the reset vector. On a qualified read strobe it runs one SPI READ (0x03) transaction:
- 8-bit command;
- 24-bit word-aligned address;
- 32 data bits.

It holds `rbusy` high until the little-endian word is on `rdata`. Address decode and gating of `rstrb` to this window happen outside the block.

## Interface
- `ADDR_WIDTH`, 24: flash byte-address width sent on the wire. Must be 24.
- `READ_CMD`, 8'h03: SPI read opcode.

Ports:
- `clk`  in  1  system clock; all outputs change only on its rising edge or on reset.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rstrb`  in  1  one-cycle read request, already qualified by the address decoder.
- `addr`  in  `ADDR_WIDTH`  byte address. Sampled only in the cycle `rstrb` is high. Bits [1:0] are ignored.
- `rdata`  out  32  read word. Byte at the lowest flash address sits in [7:0].
- `rbusy`  out  1  high while a transaction is in flight.
- `spi_cs_n`  out  1  flash chip select, active low.
- `spi_clk`  out  1  SPI clock, mode 0. Idles low.
- `spi_mosi`  out  1  serial data to flash, MSB first.
- `spi_miso`  in  1  serial data from flash.

## Operation
States: IDLE, SEND, RECV.

- **Reset** (`reset_n` low, takes effect immediately):
  - state = IDLE;
  - `spi_cs_n` = 1, `spi_clk` = 0, `spi_mosi` = 0;
  - `rbusy` = 0, `rdata` = 0;
  - bit counter = 0.
  - Reset mid-transaction aborts it: CS rises at once and no partial word is written to `rdata`.
- **IDLE**, with `rstrb` = 1 at a rising edge:
  - latch the 32-bit shift word `{READ_CMD, addr[23:2], 2'b00}`;
  - set `spi_cs_n` = 0, `rbusy` = 1, `spi_mosi` = shift word bit 31;
  - clear the counter and go to SEND.
- **Bit period** (SEND and RECV alike): 2 clk cycles.
  - Phase L: `spi_clk` = 0.
  - Phase H: `spi_clk` = 1; the flash samples MOSI on this rising edge.
  - At the edge that ends phase H:
    - `spi_clk` returns to 0;
    - the counter increments;
    - in SEND, the shift word shifts left and `spi_mosi` takes the next bit;
    - in RECV, `spi_miso` is shifted into the LSB of the receive register.
- **SEND → RECV**: after 32 bits. `spi_mosi` is driven 0 throughout RECV.
- **RECV → IDLE**: after 32 bits. At that edge:
  - receive register `{b0,b1,b2,b3}` is written to `rdata` as `{b3,b2,b1,b0}`, i.e. `rdata` = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  - `spi_cs_n` = 1, `rbusy` = 0.
- `rdata` holds its value until the next completed transaction.
- `rstrb` while `rbusy` = 1 is a protocol violation and is ignored. No queueing.
- `rstrb` in the first cycle after completion is accepted. This guarantees CS is high for at least one clk cycle between transactions.
- The counter is 5 bits plus the state bit. It wraps only via the state transitions, never free-running.

## Timing
- Request in cycle 0:
  - `rbusy` = 1 and `spi_cs_n` = 0 in cycles 1..128;
  - `rbusy` = 0 with valid `rdata` in cycle 129.
- Fixed latency: exactly 128 busy cycles, independent of address.
- `rbusy` is registered, so it is already high in the cycle after `rstrb`. A requester that samples `rbusy` one cycle after strobing therefore never sees a false "ready".
- `spi_clk` frequency = clk/2. The first rising `spi_clk` edge is in cycle 2.
- MOSI changes only on edges where `spi_clk` goes or stays low. MISO is sampled only at the end of phase H.
- All SPI outputs come directly from flops; no combinational paths to pins.

## Structure
- Shared package `spi_flash_pkg`:
  - state enum (IDLE, SEND, RECV);
  - `SPI_READ_CMD` = 8'h03;
  - `SPI_XFER_BITS` = 32.
- Single flat module; no sub-module needed. Shift, counter and phase logic are local.

## Test plan
- **Reset defaults:** reset asserted → `spi_cs_n`=1, `spi_clk`=0, `rbusy`=0, `rdata`=0, checked asynchronously without a clk edge.
- **Basic read:** `rstrb` with `addr`=0x010000 and flash model holding bytes 13 00 00 00 at that address → MOSI carries 0x03,0x01,0x00,0x00; `rbusy` high for exactly 128 cycles; `rdata`=0x00000013.
- **Alignment and byte order:** `addr`=0x0ABCDF → wire address 0x0ABCDC; model bytes DE AD BE EF → `rdata`=0xEFBEADDE.
- **Back-to-back reads:** `rstrb` issued in the first cycle `rbusy`=0 → CS high exactly 1 cycle, second transaction correct.
- **Strobe while busy:** `rstrb` pulsed mid-transfer → ignored; current result unaffected and no extra transaction follows.
- **Reset mid-transfer:** `reset_n` low at cycle 70 → CS high immediately and `rdata` still 0. After release, a new read completes normally.
